// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, types and helpers for the pipeline hazard sequencer.
// Scoreboard entries and the per-cycle fetch decision live here.
package pipe_hazard_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int          NUM_STAGES   = 3;
    localparam logic [4:0]  ZERO_REG     = 5'd0;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [15:0] STALL_MAX    = 16'hFFFF;

    typedef struct packed {
        logic       we;
        logic [4:0] dst;
    } sb_entry_t;

    typedef enum logic [1:0] {
        DEC_HOLD     = 2'd0,
        DEC_REDIRECT = 2'd1,
        DEC_STALL    = 2'd2,
        DEC_RUN      = 2'd3
    } decision_t;

    // An in-flight writer blocks ID only if it really writes a non-$0 register that ID reads.
    function automatic logic entry_hits(
        input sb_entry_t  e,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return e.we && (e.dst != ZERO_REG) &&
               ((use_rs && (e.dst == rs)) || (use_rt && (e.dst == rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Shift register of in-flight writers (EX, MEM and optionally WB) and the
// RAW comparison against the instruction currently in ID.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift_en,
    input  logic       bubble,
    input  logic       id_valid,
    input  logic       id_we,
    input  logic [4:0] id_dst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       redirect,
    output logic       hazard
);

    // With bypass the WB writer is already visible to ID, so its slot is not kept.
    localparam int CHECKED = WB_BYPASS ? (NUM_STAGES - 1) : NUM_STAGES;

    sb_entry_t sb_r [CHECKED];
    sb_entry_t new_s;
    logic      hit_s;

    // Entry entering EX: a bubble when ID/EX is flushed.
    always_comb begin
        new_s = '{we: 1'b0, dst: ZERO_REG};
        if (bubble) begin
            new_s = '{we: 1'b0, dst: ZERO_REG};
        end else begin
            new_s = '{we: id_valid & id_we, dst: id_dst};
        end
    end

    // Advance the writer pipeline on every non-frozen edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHECKED; i++) begin
                sb_r[i] <= '{we: 1'b0, dst: ZERO_REG};
            end
        end else if (shift_en) begin
            sb_r[0] <= new_s;
            for (int i = 1; i < CHECKED; i++) begin
                sb_r[i] <= sb_r[i-1];
            end
        end
    end

    // Any checked writer matching an ID source operand.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < CHECKED; i++) begin
            if (entry_hits(sb_r[i], id_rs, id_rt, id_use_rs, id_use_rt)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // A resolving redirect kills the ID instruction, so it cannot stall.
    always_comb begin
        if (id_valid && !redirect) begin
            hazard = hit_s;
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Fetch sequencer for a 5-stage pipeline without forwarding: owns the PC,
// stalls on RAW hazards, flushes wrong-path work on EX redirects.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_we,
    input  logic [4:0]  id_dst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [15:0] stall_cnt
);

    logic        hazard_s;
    decision_t   dec_s;
    logic [31:0] pc_next_s;
    logic [31:0] pc_r;
    logic [15:0] stall_cnt_r;

    hazard_scoreboard #(
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (!freeze),
        .bubble    (idex_flush),
        .id_valid  (id_valid),
        .id_we     (id_we),
        .id_dst    (id_dst),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .redirect  (redirect),
        .hazard    (hazard_s)
    );

    // Priority: freeze, then redirect, then hazard stall, then sequential fetch.
    always_comb begin
        dec_s = DEC_RUN;
        if (freeze) begin
            dec_s = DEC_HOLD;
        end else if (redirect) begin
            dec_s = DEC_REDIRECT;
        end else if (hazard_s) begin
            dec_s = DEC_STALL;
        end else begin
            dec_s = DEC_RUN;
        end
    end

    // Pipeline-control strobes and next fetch address for the chosen decision.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pc_next_s  = pc_r;
        case (dec_s)
            DEC_HOLD: begin
                pc_en = 1'b0;
            end
            DEC_REDIRECT: begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                pc_next_s  = redirect_pc;
            end
            DEC_STALL: begin
                idex_flush = 1'b1;
            end
            DEC_RUN: begin
                pc_en     = 1'b1;
                ifid_en   = 1'b1;
                pc_next_s = pc_r + PC_STEP;
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    // PC register and saturating hazard-stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            stall_cnt_r <= 16'd0;
        end else begin
            if (pc_en) begin
                pc_r <= pc_next_s;
            end
            if ((dec_s == DEC_STALL) && (stall_cnt_r != STALL_MAX)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    assign pc        = pc_r;
    assign stall_cnt = stall_cnt_r;

endmodule
